// File: rtl/prog_imem.sv
// prog_imem -- program instruction memory with clear, load and fetch phases.
//
// After reset the block walks every word and writes FILL_WORD (CLEAR, exactly
// DEPTH cycles). It then accepts loader words sequentially from address 0
// (LOAD) until a word marked prog_last is taken or the last address is
// written. From then on it serves fetches (RUN) until the next reset.
//
// Handshakes:
//   loader : a word transfers on a rising edge where prog_valid & prog_ready.
//            prog_ready is high only in LOAD; offers in other states are dropped.
//   fetch  : fetch_gnt = run & fetch_req & (~fetch_valid | fetch_ready).
//            A grant loads the output register on the next edge.
//            The output word is consumed on an edge where fetch_valid & fetch_ready.
//            While fetch_valid & ~fetch_ready the output word holds.
//
// Optional feature: define IMEM_PARITY_EN to store an even-parity bit per
// word and flag mismatches on parity_err; otherwise parity_err is tied to 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   prog_valid/ready    loader handshake; prog_data word, prog_last final word
//   fetch_req/addr/gnt  fetch request, word address, grant
//   fetch_valid/ready   fetch output handshake
//   fetch_data/err      fetched word; err set for addresses >= DEPTH
//   run                 high in RUN
//   load_count          words written by the loader since reset
//   parity_err          parity mismatch on the current output word
module prog_imem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter logic [DATA_W-1:0] FILL_WORD = 32'hFC00_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_last,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  output logic              run,
  output logic [ADDR_W:0]   load_count,
  output logic              parity_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t state;
  logic [ADDR_W-1:0] clr_ptr;

  logic [DATA_W-1:0] mem [DEPTH];

  // Single write port shared by the clear pass and the loader.
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = FILL_WORD;
    case (state)
      ST_CLEAR: begin
        wr_en  = 1'b1;
        wr_idx = clr_ptr[IDX_W-1:0];
      end
      ST_LOAD: begin
        wr_en   = prog_valid;
        wr_idx  = load_count[IDX_W-1:0];
        wr_data = prog_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) par_mem[wr_idx] <= ^wr_data;
  end
`endif

  // Control FSM. prog_ready and run are registered alongside the state so
  // they change on the same edge as the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_CLEAR;
      clr_ptr    <= '0;
      load_count <= '0;
      prog_ready <= 1'b0;
      run        <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_ptr == LAST_ADDR) begin
            state      <= ST_LOAD;
            prog_ready <= 1'b1;
            clr_ptr    <= '0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        ST_LOAD: begin
          if (prog_valid) begin
            load_count <= load_count + 1'b1;
            // Leaving on the last address keeps the pointer from ever wrapping.
            if (prog_last || (load_count == LAST_CNT)) begin
              state      <= ST_RUN;
              prog_ready <= 1'b0;
              run        <= 1'b1;
            end
          end
        end
        ST_RUN: ;
        default: begin
          state      <= ST_CLEAR;
          clr_ptr    <= '0;
          prog_ready <= 1'b0;
          run        <= 1'b0;
        end
      endcase
    end
  end

  // Fetch path: one output register, refilled on a grant.
  logic             in_range;
  logic [IDX_W-1:0] rd_idx;

  assign fetch_gnt = run & fetch_req & (~fetch_valid | fetch_ready);
  assign in_range  = ({1'b0, fetch_addr} < DEPTH_EXT);
  assign rd_idx    = fetch_addr[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
      fetch_err   <= 1'b0;
    end else if (fetch_gnt) begin
      fetch_valid <= 1'b1;
      fetch_data  <= in_range ? mem[rd_idx] : FILL_WORD;
      fetch_err   <= ~in_range;
    end else if (fetch_ready) begin
      fetch_valid <= 1'b0;
    end
  end

`ifdef IMEM_PARITY_EN
  // Out-of-range fetches never touch the array, so they cannot flag parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (fetch_gnt) begin
      parity_err <= in_range && (par_mem[rd_idx] != ^mem[rd_idx]);
    end else if (fetch_ready) begin
      parity_err <= 1'b0;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/prog_imem.md
PROG_IMEM -- requirements
Module: prog_imem

Interface
REQ-001 Parameter DATA_W, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 1024, number of words.
REQ-003 Parameter ADDR_W, default 10, address width; DEPTH SHALL be at most 2**ADDR_W.
REQ-004 Parameter FILL_WORD, default 32'hFC00_0000 (halt opcode), value written to every word by the clear pass.
REQ-005 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 Port prog_valid  input  1  loader word present.
REQ-008 Port prog_ready  output  1  loader word accepted this cycle when prog_valid is also high.
REQ-009 Port prog_data  input  DATA_W  loader word.
REQ-010 Port prog_last  input  1  final loader word.
REQ-011 Port fetch_req  input  1  fetch request.
REQ-012 Port fetch_addr  input  ADDR_W  fetch word address.
REQ-013 Port fetch_gnt  output  1  request accepted this cycle.
REQ-014 Port fetch_valid  output  1  fetch_data and fetch_err valid.
REQ-015 Port fetch_ready  input  1  consumer takes the output word.
REQ-016 Port fetch_data  output  DATA_W  fetched word.
REQ-017 Port fetch_err  output  1  fetched address was >= DEPTH.
REQ-018 Port run  output  1  block in RUN state.
REQ-019 Port load_count  output  ADDR_W+1  words written by the loader since reset.
REQ-020 Port parity_err  output  1  parity mismatch on the current output word (see REQ-036).

Function
REQ-021 The state machine SHALL have three states: CLEAR, LOAD and RUN.
REQ-022 In CLEAR, the block SHALL write FILL_WORD to address k in cycle k, for k = 0..DEPTH-1, then enter LOAD; CLEAR SHALL last exactly DEPTH cycles.
REQ-023 In LOAD, prog_ready SHALL be 1, and every cycle with prog_valid=1 SHALL write prog_data at the pointer and then increment both the pointer and load_count.
REQ-024 LOAD SHALL exit to RUN on the cycle after the handshake that carries prog_last=1, or after the handshake that writes address DEPTH-1, whichever comes first.
REQ-025 In CLEAR and RUN, prog_ready SHALL be 0; loader words offered in these states SHALL be ignored.
REQ-026 The formula fetch_gnt = run & fetch_req & (~fetch_valid | fetch_ready) SHALL hold.
REQ-027 On a grant, the addressed word SHALL appear on fetch_data with fetch_valid=1 on the next cycle (1-cycle latency).
REQ-028 Throughput SHALL be 1 word per cycle while fetch_ready=1.
REQ-029 While fetch_valid=1 and fetch_ready=0, fetch_data, fetch_err and parity_err SHALL hold stable.
REQ-030 When the output word is taken (fetch_valid=1, fetch_ready=1) with no new grant, fetch_valid SHALL fall next cycle.
REQ-031 A granted fetch_addr >= DEPTH SHALL return FILL_WORD with fetch_err=1 and SHALL NOT alter memory.
REQ-032 The loader pointer SHALL never wrap; a write beyond DEPTH-1 SHALL NOT occur.

Reset
REQ-033 While rst_n=0: state=CLEAR, pointer=0, load_count=0, and prog_ready, fetch_gnt, fetch_valid, fetch_err, parity_err, run all 0; fetch_data=0.
REQ-034 Reset asserted mid-LOAD or mid-RUN SHALL abort the operation immediately; the block SHALL rerun CLEAR after release.
REQ-035 Memory contents SHALL NOT be guaranteed until CLEAR completes.

Configuration
REQ-036 With macro IMEM_PARITY_EN defined, each word SHALL store an extra even-parity bit computed on write; parity_err SHALL assert with fetch_valid when the stored parity mismatches.
REQ-037 Without IMEM_PARITY_EN, no parity storage SHALL exist, and parity_err SHALL be tied to 0.

Verification (DEPTH=16, DATA_W=32)
REQ-038 Release reset -> prog_ready=0 for 16 cycles, then 1; a read of address 5 after LOAD with no loader words written returns 32'hFC00_0000.
REQ-039 Load 3 words (0x20010005, 0x20220003, 0x00221820), prog_last on the third -> load_count=3, run=1 next cycle; fetches 0,1,2 return those words, 1 cycle after each grant.
REQ-040 Load 20 words without prog_last -> only 16 accepted, run=1 after the 16th, load_count=16.
REQ-041 In RUN, request addr 1 with fetch_ready=0 for 4 cycles -> fetch_data holds, fetch_gnt=0 for the held cycles; raise fetch_ready -> next word follows back-to-back.
REQ-042 Fetch addr 20 -> fetch_data=32'hFC00_0000, fetch_err=1.
REQ-043 Pulse rst_n low after 2 of 3 loader words -> load_count=0, CLEAR repeats 16 cycles, and address 0 reads FILL_WORD; with IMEM_PARITY_EN defined, forcing a stored parity bit flip yields parity_err=1.
